// File: rtl/neuron_mac.sv
// One neuron of a layer datapath: serially accumulates K signed Q-format
// w*x products on a 2N-bit bias, rounds, saturates, optionally applies ReLU.
module neuron_mac #(
    parameter int N = 8,
    parameter int Q = 7,
    parameter int K = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   w,
    input  logic signed [N-1:0]   x,
    input  logic signed [2*N-1:0] b,
    input  logic                  relu,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N-1:0]   out,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);

    localparam int ACC_W = 2 * N + $clog2(K) + 1;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K - 1);

    localparam logic [1:0] S_ACC = 2'd0;
    localparam logic [1:0] S_FIN = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;

    localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'((Q > 0) ? (2 ** (Q - 1)) : 0);
    localparam logic signed [N-1:0]   SAT_MAX = {1'b0, {(N - 1){1'b1}}};
    localparam logic signed [N-1:0]   SAT_MIN = {1'b1, {(N - 1){1'b0}}};

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and out/ovf hold while out_valid && !out_ready.
    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [N-1:0]      out_q, out_d;
    logic                     ovf_q, ovf_d;

    logic signed [2*N-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W:0]    sum_rnd;
    logic signed [ACC_W:0]    r;
    logic signed [N-1:0]      sat;
    logic                     sat_ovf;

    assign prod     = (2 * N)'(w) * (2 * N)'(x);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(b);

    // Round-half-up then arithmetic shift back to Q fractional bits.
    assign sum_rnd = (ACC_W + 1)'(acc_q) + RND;
    assign r       = sum_rnd >>> Q;

    always_comb begin
        sat     = r[N-1:0];
        sat_ovf = 1'b0;
        if (r > (ACC_W + 1)'(SAT_MAX)) begin
            sat     = SAT_MAX;
            sat_ovf = 1'b1;
        end else if (r < (ACC_W + 1)'(SAT_MIN)) begin
            sat     = SAT_MIN;
            sat_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    acc_d = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                out_d       = (relu && sat[N-1]) ? '0 : sat;
                ovf_d       = sat_ovf;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: expected {ovf,out} pairs are queued at issue
// time and a negedge monitor pops one per output handshake.
module tb_neuron_mac;

    localparam int N = 8;
    localparam int Q = 7;
    localparam int K = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [N-1:0]   w;
    logic signed [N-1:0]   x;
    logic signed [2*N-1:0] b;
    logic                  relu;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [N-1:0]   out;
    logic                  ovf;
    logic [1:0]            dbg_state;

    int checks = 0;
    int errors = 0;

    logic [N:0] exp_q[$];
    string      name_q[$];
    logic [N:0] mon_exp;
    string      mon_name;

    neuron_mac #(.N(N), .Q(Q), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w         (w),
        .x         (x),
        .b         (b),
        .relu      (relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_res(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {ovf,out}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one pop per completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got {ovf,out}=%h expected no result", {ovf, out});
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check_res(mon_name, {ovf, out}, mon_exp);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_bit("in_ready_timeout", in_ready, 1'b1);
    endtask

    // Later beats carry random bias, which must not affect the result.
    task automatic run_eval(input string name, input logic [K*N-1:0] wv, input logic [K*N-1:0] xv,
                            input logic [2*N-1:0] bias, input logic rl, input int gap,
                            input logic [N:0] exp);
        int lat;
        exp_q.push_back(exp);
        name_q.push_back(name);
        relu = rl;
        for (int i = 0; i < K; i++) begin
            w        = wv[(K-1-i)*N +: N];
            x        = xv[(K-1-i)*N +: N];
            b        = (i == 0) ? bias : 16'($urandom);
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < K - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        // Beat cycle is cycle 0, FIN is cycle 1, result visible in cycle 2.
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_int({name, "_latency"}, lat, 2);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        w         = '0;
        x         = '0;
        b         = '0;
        relu      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_res("rst_out", {ovf, out}, 9'h000);
        check_int("rst_state", int'(dbg_state), 0);
        rst = 1'b0;

        run_eval("sat_pos", {4{8'h40}}, {4{8'h40}}, 16'h0000, 1'b0, 0, {1'b1, 8'h7F});
        drain();
        run_eval("quarter", {8'h40, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 0, {1'b0, 8'h20});
        drain();
        run_eval("neg_quarter", {8'hC0, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 0, {1'b0, 8'hE0});
        drain();
        run_eval("neg_quarter_relu", {8'hC0, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b1, 0, {1'b0, 8'h00});
        drain();
        run_eval("round_p64", 32'h0, 32'h0, 16'h0040, 1'b0, 0, {1'b0, 8'h01});
        drain();
        run_eval("round_m64", 32'h0, 32'h0, 16'hFFC0, 1'b0, 0, {1'b0, 8'h00});
        drain();
        run_eval("round_m65", 32'h0, 32'h0, 16'hFFBF, 1'b0, 0, {1'b0, 8'hFF});
        drain();
        run_eval("sat_neg", {4{8'h80}}, {4{8'h7F}}, 16'h0000, 1'b0, 0, {1'b1, 8'h80});
        drain();
        run_eval("sat_neg_relu", {4{8'h80}}, {4{8'h7F}}, 16'h0000, 1'b1, 0, {1'b1, 8'h00});
        drain();
        run_eval("no_wrap", {4{8'h80}}, {4{8'h80}}, 16'h0000, 1'b0, 0, {1'b1, 8'h7F});
        drain();
        run_eval("gap1", {8'h40, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 1, {1'b0, 8'h20});
        drain();
        run_eval("gap3_sat", {4{8'h40}}, {4{8'h40}}, 16'h0000, 1'b0, 3, {1'b1, 8'h7F});
        drain();

        // Backpressure: result held, input blocked, stray beat ignored.
        out_ready = 1'b0;
        run_eval("backpressure", {8'h20, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 0, {1'b0, 8'h10});
        w        = 8'h7F;
        x        = 8'h7F;
        b        = 16'h7FFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_res("bp_hold", {ovf, out}, {1'b0, 8'h10});
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check_bit("bp_in_ready_after", in_ready, 1'b1);
        check_res("bp_out_retained", {ovf, out}, {1'b0, 8'h10});
        run_eval("after_bp", {8'h40, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 0, {1'b0, 8'h20});
        drain();

        // Reset after two beats discards the partial evaluation.
        w        = 8'h7F;
        x        = 8'h7F;
        b        = 16'h7FFF;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_bit("mid_rst_in_ready", in_ready, 1'b1);
        check_res("mid_rst_out", {ovf, out}, 9'h000);
        run_eval("after_rst", {8'h40, 24'h0}, {8'h40, 24'h0}, 16'h0000, 1'b0, 0, {1'b0, 8'h20});
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
